mem_bus_responder: RTL

Memory-side responder (target) for the CPU data/instruction bus.
- Accepts one request at a time over a valid/ready channel.
- Performs a word read or byte-enabled write on internal storage.
- Returns a response after a programmable number of wait states.
- Lets the multi-cycle and pipelined CPUs be exercised against non-zero memory latency instead of the ideal zero-wait RAM.

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_bus_wait_ctr.sv | 27 ++
 rtl/mem_bus_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory-bus responder.
package mem_bus_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_bus_state_t;

    localparam int WORD_BYTES = 4;
    localparam int BE_W       = 4;
    localparam int CTR_W      = 4;

    function automatic logic [8*WORD_BYTES-1:0] be_merge(
        input logic [8*WORD_BYTES-1:0] old_word,
        input logic [8*WORD_BYTES-1:0] new_word,
        input logic [BE_W-1:0]         be
    );
        logic [8*WORD_BYTES-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_bus_wait_ctr.sv
// Loadable down-counter that sequences the responder's wait states.
module mem_bus_wait_ctr
    import mem_bus_pkg::*;
#(
    parameter int W = CTR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 cnt <= '0;
        else if (load)              cnt <= load_val;
        else if (en && cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign value = cnt;
    assign done  = (cnt == '0);

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder with programmable wait states.
// Optional address fault checking is enabled by defining MEM_BUS_ERR_CHECK_EN.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int               AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [29:0]      DEPTH_W  = 30'(MEM_DEPTH);
    localparam logic [CTR_W-1:0] LOAD_VAL = (LATENCY == 0) ? '0 : CTR_W'(LATENCY - 1);

    logic [31:0] mem [0:MEM_DEPTH-1];

    mem_bus_state_t state, next_state;

    logic          accept;
    logic          fault;
    logic          mem_we;
    logic [29:0]   word_full;
    logic [AW-1:0] idx;
    logic [31:0]   rdata_q;
    logic          ctr_done;
    logic [CTR_W-1:0] unused_ctr_value;

    assign accept    = req_ready && req_valid;
    assign word_full = req_addr[31:2];
    // Modulo keeps the index in range even for non-power-of-two depths.
    assign idx       = AW'(word_full % DEPTH_W);

`ifdef MEM_BUS_ERR_CHECK_EN
    logic err_q;

    assign fault = (req_addr[1:0] != 2'b00) || (word_full >= DEPTH_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      err_q <= 1'b0;
        else if (accept) err_q <= fault;
    end

    assign rsp_err = err_q;
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];
    assign fault           = 1'b0;
    assign rsp_err         = 1'b0;
`endif

    // Gating with reset keeps a request presented during reset out of storage.
    assign mem_we = accept && req_we && !fault && reset;

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= be_merge(mem[idx], req_wdata, req_be);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      rdata_q <= '0;
        else if (accept) rdata_q <= (req_we || fault) ? '0 : mem[idx];
    end

    assign rsp_rdata = rdata_q;

    mem_bus_wait_ctr #(
        .W (CTR_W)
    ) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .en       (state == WAIT),
        .load_val (LOAD_VAL),
        .value    (unused_ctr_value),
        .done     (ctr_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept)    next_state = (LATENCY == 0) ? RESP : WAIT;
            WAIT: if (ctr_done)  next_state = RESP;
            RESP: if (rsp_ready) next_state = IDLE;
            default:             next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule
